bcd_frame_host: RTL and testbench
=================================

BCD_FRAME_HOST -- requirements
Module: bcd_frame_host

Interface
REQ-001 Parameter START_PATTERN, default 8'h5A, is the frame sync byte sent before the operands.
REQ-002 Parameter RESULT_HEADER, default 8'h96, is the header byte that precedes a returned result.
REQ-003 Parameter TIMEOUT, default 64, is the maximum number of cycles spent hunting for RESULT_HEADER.
REQ-004 The ports SHALL be as follows, clock and reset first:
- clock  input  1  sole clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to send one frame; sampled only in IDLE.
- add_sub  input  1  operation bit: 0 = add, 1 = subtract.
- a  input  16  operand A, 4 BCD digits, [15:12] most significant.
- b  input  16  operand B, 4 BCD digits.
- dout  output  1  serial stream to the calculator's din.
- din  input  1  serial stream from the calculator's result.
- busy  output  1  high in every state except IDLE.
- result  output  20  last captured 5-digit BCD result.
- done  output  1  one-cycle pulse when result is updated.
- timeout_err  output  1  one-cycle pulse when the header hunt expires.

Function
REQ-005 The FSM SHALL have four states: IDLE, SEND, HUNT and CAPTURE.
REQ-006 In IDLE, start=1 SHALL latch {START_PATTERN, add_sub, a, b} into a 41-bit shift register and move to SEND on the next edge.
REQ-007 In SEND, dout SHALL present one frame bit per cycle, MSB first, in this order:
- 8 sync bits;
- the add_sub bit;
- a[15] down to a[0];
- b[15] down to b[0].
REQ-008 The first frame bit SHALL appear on dout in the cycle after start is sampled; the frame occupies exactly 41 consecutive cycles.
REQ-009 dout SHALL be driven from a register and SHALL be 0 in every cycle outside SEND.
REQ-010 After the 41st bit, the FSM SHALL enter HUNT, clear the 8-bit receive shift register and clear a cycle counter.
REQ-011 In HUNT, each cycle SHALL shift din into the receive register LSB-side; a match is {rx[6:0], din} == RESULT_HEADER, evaluated in the same cycle.
REQ-012 On a match, the FSM SHALL move to CAPTURE; the first result bit is the din sampled in the following cycle.
REQ-013 Overlapping or prefixed patterns SHALL be detected: any 8 consecutive din bits equal to RESULT_HEADER match.
REQ-014 If TIMEOUT cycles elapse in HUNT without a match, timeout_err SHALL pulse for one cycle, the FSM SHALL return to IDLE, and result SHALL be left unchanged.
REQ-015 In CAPTURE, 20 din bits SHALL be shifted in MSB first into a capture register, using a 5-bit counter.
REQ-016 On the 20th bit, the full value SHALL be written to result, done SHALL pulse in the next cycle, and the FSM SHALL return to IDLE.
REQ-017 result SHALL hold its value between captures; no BCD validity check is performed on it.
REQ-018 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-019 A start sampled in IDLE in the same cycle as done SHALL be accepted.
REQ-020 done and timeout_err SHALL never be high in the same cycle.

Reset
REQ-021 reset=0 SHALL immediately, without waiting for a clock edge, force:
- the FSM to IDLE;
- dout, busy, done and timeout_err to 0;
- result to 20'h00000;
- all shift registers and counters to 0.
REQ-022 Reset asserted mid-SEND or mid-CAPTURE SHALL abort the frame with no partial result written; operation resumes on the first rising edge after reset deasserts.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Frame order: start with add_sub=0, a=16'h1234, b=16'h5678 -> dout over 41 cycles = 01011010, 0, 0001001000110100, 0101011001111000; then dout=0 and busy=1.
- Add result: in HUNT drive din = 1,1 then 10010110 then 20'h06912 MSB first -> result=20'h06912, done high for exactly one cycle, busy=0 afterwards.
- Subtract: add_sub=1, a=16'h5000, b=16'h1234, din returns header + 20'h03766 -> frame bit 9 = 1, result=20'h03766.
- Timeout: din held at 0 for 64 cycles in HUNT -> timeout_err pulse; result retains its previous value 20'h06912; FSM returns to IDLE.
- Busy guard: pulse start at cycle 10 of SEND with a=16'h9999 -> the frame in flight is unchanged and no second frame is sent.
- Reset: reset=0 at bit 20 of SEND, released 3 cycles later -> dout=0, busy=0, result=0 with no clock edge needed; a new start then sends a complete 41-bit frame.

Source files
------------

// File: rtl/bcd_frame_host.sv
// Host-side framer for a serial BCD calculator. It sends one
// {sync, op, A, B} frame MSB first, hunts for the result header on din,
// then captures a 20-bit (5-digit) BCD result.
module bcd_frame_host #(
  parameter logic [7:0]  START_PATTERN = 8'h5A,
  parameter logic [7:0]  RESULT_HEADER = 8'h96,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        add_sub,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        dout,
  input  logic        din,
  output logic        busy,
  output logic [19:0] result,
  output logic        done,
  output logic        timeout_err
);

  localparam int unsigned FRAME_W = 41;
  localparam int unsigned SEND_CW = 6;
  localparam int unsigned RES_W   = 20;
  localparam int unsigned CAP_CW  = 5;
  localparam int unsigned HDR_W   = 8;
  localparam int unsigned HUNT_CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_HUNT,
    ST_CAPTURE
  } state_e;

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [SEND_CW-1:0]   send_cnt_q, send_cnt_d;
  // Seven bits of header history; the eighth bit is the live din.
  logic [HDR_W-2:0]     rx_q, rx_d;
  logic [HUNT_CW-1:0]   hunt_cnt_q, hunt_cnt_d;
  // Partial result; the final bit goes straight from din to result.
  logic [RES_W-2:0]     cap_q, cap_d;
  logic [CAP_CW-1:0]    cap_cnt_q, cap_cnt_d;
  logic                 dout_q, dout_d;
  logic                 busy_q, busy_d;
  logic [RES_W-1:0]     result_q, result_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;

  logic [FRAME_W-1:0]   frame_load;
  logic [HDR_W-1:0]     rx_next;
  logic [RES_W-1:0]     cap_next;

  assign frame_load = {START_PATTERN, add_sub, a, b};
  assign rx_next    = {rx_q, din};
  assign cap_next   = {cap_q, din};

  // Next-state and registered-output logic for the frame/hunt/capture sequence.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    send_cnt_d = send_cnt_q;
    rx_d       = rx_q;
    hunt_cnt_d = hunt_cnt_q;
    cap_d      = cap_q;
    cap_cnt_d  = cap_cnt_q;
    result_d   = result_q;
    dout_d     = 1'b0;
    done_d     = 1'b0;
    timeout_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          // First frame bit goes out in the very next cycle.
          dout_d     = frame_load[FRAME_W-1];
          frame_d    = {frame_load[FRAME_W-2:0], 1'b0};
          send_cnt_d = '0;
          state_d    = ST_SEND;
        end
      end

      ST_SEND: begin
        if (send_cnt_q == SEND_CW'(FRAME_W - 1)) begin
          rx_d       = '0;
          hunt_cnt_d = '0;
          state_d    = ST_HUNT;
        end else begin
          dout_d     = frame_q[FRAME_W-1];
          frame_d    = {frame_q[FRAME_W-2:0], 1'b0};
          send_cnt_d = send_cnt_q + SEND_CW'(1);
        end
      end

      ST_HUNT: begin
        rx_d = rx_next[HDR_W-2:0];
        if (rx_next == RESULT_HEADER) begin
          cap_d     = '0;
          cap_cnt_d = '0;
          state_d   = ST_CAPTURE;
        end else if (hunt_cnt_q == HUNT_CW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          hunt_cnt_d = hunt_cnt_q + HUNT_CW'(1);
        end
      end

      ST_CAPTURE: begin
        cap_d = cap_next[RES_W-2:0];
        if (cap_cnt_q == CAP_CW'(RES_W - 1)) begin
          result_d = cap_next;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cap_cnt_d = cap_cnt_q + CAP_CW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      send_cnt_q <= '0;
      rx_q       <= '0;
      hunt_cnt_q <= '0;
      cap_q      <= '0;
      cap_cnt_q  <= '0;
      result_q   <= '0;
      dout_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      send_cnt_q <= send_cnt_d;
      rx_q       <= rx_d;
      hunt_cnt_q <= hunt_cnt_d;
      cap_q      <= cap_d;
      cap_cnt_q  <= cap_cnt_d;
      result_q   <= result_d;
      dout_q     <= dout_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  assign dout        = dout_q;
  assign busy        = busy_q;
  assign result      = result_q;
  assign done        = done_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_bcd_frame_host.sv
// Scoreboard bench for bcd_frame_host: stimulus pushes expected frames,
// results and timeouts; a negedge monitor pops and compares them.
module tb_bcd_frame_host;

  logic        clock;
  logic        reset;
  logic        start;
  logic        add_sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        din;
  logic        dout;
  logic        busy;
  logic [19:0] result;
  logic        done;
  logic        timeout_err;

  localparam logic [1:0] K_FRAME   = 2'd0;
  localparam logic [1:0] K_RESULT  = 2'd1;
  localparam logic [1:0] K_TIMEOUT = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [40:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  bcd_frame_host dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .add_sub    (add_sub),
    .a          (a),
    .b          (b),
    .dout       (dout),
    .din        (din),
    .busy       (busy),
    .result     (result),
    .done       (done),
    .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [40:0] act, input logic [40:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [40:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic expect_event(input string name, input logic [1:0] kind, input logic [40:0] act);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: unexpected event value %0h, nothing expected", name, act);
    end else begin
      e = exp_q.pop_front();
      check({name, "_kind"}, 41'(kind), 41'(e.kind));
      check(name, act, e.val);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic issue(input logic op, input logic [15:0] av, input logic [15:0] bv);
    start   = 1'b1;
    add_sub = op;
    a       = av;
    b       = bv;
    push(K_FRAME, {8'h5A, op, av, bv});
    tick();
    start = 1'b0;
  endtask

  task automatic drive_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      din = v[i];
      tick();
    end
  endtask

  // Monitor: collects each frame from busy's rising edge and checks pulses.
  logic        coll;
  logic        post;
  logic        busy_p;
  logic        done_p;
  int          nbits;
  logic [40:0] fr;

  initial begin
    coll = 1'b0; post = 1'b0; busy_p = 1'b0; done_p = 1'b0; nbits = 0; fr = '0;
  end

  always @(negedge clock) begin
    if (!reset) begin
      coll   = 1'b0;
      post   = 1'b0;
      busy_p = 1'b0;
      done_p = 1'b0;
    end else begin
      if (done && timeout_err)
        check("done_and_timeout", 41'(1), 41'(0));
      if (done_p)
        check("done_width", 41'(done), 41'(0));
      if (busy && !busy_p && !coll) begin
        coll  = 1'b1;
        nbits = 0;
      end
      if (coll) begin
        fr = {fr[39:0], dout};
        nbits++;
        if (nbits == 41) begin
          coll = 1'b0;
          post = 1'b1;
          expect_event("frame", K_FRAME, fr);
        end
      end else if (post) begin
        post = 1'b0;
        check("after_frame_dout", 41'(dout), 41'(0));
        check("after_frame_busy", 41'(busy), 41'(1));
      end else if (dout) begin
        check("dout_idle", 41'(dout), 41'(0));
      end
      if (done) begin
        expect_event("result", K_RESULT, 41'(result));
        check("busy_after_done", 41'(busy), 41'(0));
      end
      if (timeout_err) begin
        expect_event("timeout_result", K_TIMEOUT, 41'(result));
        check("busy_after_timeout", 41'(busy), 41'(0));
      end
      busy_p = busy;
      done_p = done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation ran too long");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; add_sub = 1'b0; a = '0; b = '0; din = 1'b0;
    #1;
    check("rst_dout", 41'(dout), 41'(0));
    check("rst_busy", 41'(busy), 41'(0));
    check("rst_done", 41'(done), 41'(0));
    check("rst_timeout", 41'(timeout_err), 41'(0));
    check("rst_result", 41'(result), 41'(0));
    tick(2);
    reset = 1'b1;
    tick(2);

    // Add: header preceded by two stray ones.
    issue(1'b0, 16'h1234, 16'h5678);
    tick(41);
    push(K_RESULT, 41'(20'h06912));
    drive_bits(32'h396, 10);
    drive_bits(32'h06912, 20);

    // Start in the done cycle, then let the hunt time out.
    issue(1'b0, 16'h4321, 16'h8765);
    din = 1'b0;
    tick(41);
    tick(63);
    check("timeout_not_early", 41'(timeout_err), 41'(0));
    check("busy_before_timeout", 41'(busy), 41'(1));
    push(K_TIMEOUT, 41'(20'h06912));
    tick();
    check("timeout_pulse", 41'(timeout_err), 41'(1));
    tick(2);

    // Subtract.
    issue(1'b1, 16'h5000, 16'h1234);
    tick(41);
    push(K_RESULT, 41'(20'h03766));
    drive_bits(32'h96, 8);
    drive_bits(32'h03766, 20);
    din = 1'b0;
    tick(2);

    // Busy guard: second start during SEND must be dropped.
    issue(1'b0, 16'h1111, 16'h2222);
    tick(10);
    start = 1'b1; a = 16'h9999; b = 16'h9999;
    tick();
    start = 1'b0;
    tick(30);
    push(K_RESULT, 41'(20'h12345));
    drive_bits(32'h96, 8);
    drive_bits(32'h12345, 20);
    din = 1'b0;
    tick(50);

    // Reset in the middle of SEND.
    start = 1'b1; add_sub = 1'b0; a = 16'h2468; b = 16'h1357;
    tick();
    start = 1'b0;
    tick(20);
    reset = 1'b0;
    #1;
    check("mid_rst_dout", 41'(dout), 41'(0));
    check("mid_rst_busy", 41'(busy), 41'(0));
    check("mid_rst_result", 41'(result), 41'(0));
    tick(3);
    reset = 1'b1;
    tick();
    issue(1'b1, 16'h0042, 16'h0017);
    tick(41);
    push(K_TIMEOUT, 41'(0));
    tick(64);
    tick(5);

    check("queue_empty", 41'(exp_q.size()), 41'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
